// File: rtl/prio_enc_scan.sv
// prio_enc_scan: accepts a request vector and emits the index of each set bit, one per beat, in priority order
module prio_enc_scan #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       none,
  output logic [$clog2(WIDTH):0]     count
);
  localparam int IDXW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] pending;
  logic [IDXW-1:0]  idx;
  logic             load;
  logic             fire;
  assign in_ready  = (state == IDLE) && en;
  assign out_valid = (state == SCAN) && en;
  assign load      = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  // later iterations win, so scan toward the highest-priority end
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (pending[MSB_FIRST ? i : WIDTH-1-i]) idx = IDXW'(MSB_FIRST ? i : WIDTH-1-i);
  end
  assign out_idx  = out_valid ? idx : '0;
  assign out_last = out_valid && ((pending & (pending - WIDTH'(1))) == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
      none    <= 1'b0;
    end else begin
      none <= load && (in_data == '0);
      if (load) begin
        count <= '0;
        if (|in_data) begin
          pending <= in_data;
          state   <= SCAN;
        end
      end else if (fire) begin
        pending <= pending & ~(WIDTH'(1) << out_idx);
        count   <= count + (IDXW+1)'(1);
        state   <= out_last ? IDLE : SCAN;
      end
    end
  end
endmodule

// File: tb/tb_prio_enc_scan.sv
// tb_prio_enc_scan: MSB-first and LSB-first instances checked against a queue-based reference model
module tb_prio_enc_scan;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_m, vld_m, last_m, none_m, rdy_l, vld_l, last_l, none_l;
  logic [2:0] idx_m, idx_l;
  logic [3:0] cnt_m, cnt_l;
  int total = 0, passed = 0;
  bit busy = 0, nexp = 0;
  int cnt = 0;
  int qm[$], ql[$];

  prio_enc_scan #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
    .out_valid(vld_m), .out_ready(out_ready), .out_idx(idx_m), .out_last(last_m), .none(none_m), .count(cnt_m));
  prio_enc_scan #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
    .out_valid(vld_l), .out_ready(out_ready), .out_idx(idx_l), .out_last(last_l), .none(none_l), .count(cnt_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_outputs();
    bit ev, er;
    ev = busy && en;
    er = !busy && en;
    chk("m_ready", 32'(rdy_m), 32'(er));
    chk("m_valid", 32'(vld_m), 32'(ev));
    chk("m_idx",   32'(idx_m), (ev && qm.size() > 0) ? qm[0] : 0);
    chk("m_last",  32'(last_m), 32'(ev && qm.size() == 1));
    chk("m_count", 32'(cnt_m), cnt);
    chk("m_none",  32'(none_m), 32'(nexp));
    chk("l_ready", 32'(rdy_l), 32'(er));
    chk("l_valid", 32'(vld_l), 32'(ev));
    chk("l_idx",   32'(idx_l), (ev && ql.size() > 0) ? ql[0] : 0);
    chk("l_last",  32'(last_l), 32'(ev && ql.size() == 1));
    chk("l_count", 32'(cnt_l), cnt);
    chk("l_none",  32'(none_l), 32'(nexp));
  endtask

  // one clock: check at the falling edge, then advance the model across the rising edge
  task automatic cycle();
    bit ev, er, nn;
    @(negedge clk);
    check_outputs();
    ev = busy && en;
    er = !busy && en;
    nn = er && in_valid && (in_data == '0);
    if (er && in_valid) begin
      cnt = 0;
      if (in_data != '0) begin
        qm.delete();
        ql.delete();
        for (int i = W-1; i >= 0; i--) if (in_data[i]) qm.push_back(i);
        for (int i = 0; i < W; i++) if (in_data[i]) ql.push_back(i);
        busy = 1;
      end
    end else if (ev && out_ready) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      cnt++;
      if (qm.size() == 0) busy = 0;
    end
    nexp = nn;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cycle();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(vld_m | vld_l), 0);
    chk("rst_count", 32'(cnt_m | cnt_l), 0);
    chk("rst_idx",   32'(idx_m | idx_l), 0);
    chk("rst_last",  32'(last_m | last_l), 0);
    chk("rst_none",  32'(none_m | none_l), 0);
    busy = 0; cnt = 0; nexp = 0;
    qm.delete();
    ql.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    reset_now();
    en = 1'b1;
    out_ready = 1'b1;
    cycle();
    load(8'hA5);
    repeat (6) cycle();
    out_ready = 1'b0;
    load(8'h81);
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (4) cycle();
    load(8'h00);
    repeat (2) cycle();
    load(8'hFF);
    repeat (2) cycle();
    en = 1'b0;
    repeat (4) cycle();
    en = 1'b1;
    repeat (8) cycle();
    load(8'hF0);
    cycle();
    reset_now();
    cycle();
    load(8'h02);
    repeat (3) cycle();
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
